// File: rtl/mux_nway_pipe.sv
// Purpose: N-channel W-bit selector with valid/ready handshake and a 2-entry skid buffer.
// Latency: 1 cycle from input transfer to out_valid when the buffer is empty or draining.
// Backpressure: in_ready is registered (state != FULL); the skid entry absorbs one beat
//   accepted while out_ready is low, so there is no combinational ready path.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/in_sel       packed channels (channel k at [k*WIDTH +: WIDTH]) and select
//   in_valid/in_ready    input handshake
//   out_data/out_sel     selected data and the raw select that produced it
//   out_valid/out_ready  output handshake
//   sel_err              sticky flag: an accepted beat had in_sel >= CHANNELS
//   beat_count           output-transfer counter, live only with MUX_NWAY_PIPE_STATS_EN
//                        defined; tied to zero otherwise
module mux_nway_pipe #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  output logic [15:0]               beat_count
);

  // Occupancy of the main + skid pair; main always holds the oldest beat.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_dat_q, main_dat_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_dat_q, skid_dat_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               sel_err_q, sel_err_d;

  logic [WIDTH-1:0]   sel_dat;
  logic               sel_oor;
  logic               accept;
  logic               drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  // Out-of-range selects pass through as zero data with the raw select kept.
  assign sel_oor = (32'(in_sel) >= 32'(CHANNELS));

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (32'(in_sel) == 32'(k)) begin
        sel_dat = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_sel_d = main_sel_q;
    skid_dat_d = skid_dat_q;
    skid_sel_d = skid_sel_q;
    sel_err_d  = sel_err_q | (accept & sel_oor);

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_dat_d = sel_dat;
          main_sel_d = in_sel;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_dat_d = sel_dat;
          main_sel_d = in_sel;
        end else if (accept) begin
          skid_dat_d = sel_dat;
          skid_sel_d = in_sel;
          state_d    = ST_FULL;
        end else if (drain) begin
          state_d    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          main_dat_d = skid_dat_q;
          main_sel_d = skid_sel_q;
          state_d    = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Handshake outputs are registered copies of the next occupancy.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_dat_q  <= '0;
      main_sel_q  <= '0;
      skid_dat_q  <= '0;
      skid_sel_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_dat_q  <= main_dat_d;
      main_sel_q  <= main_sel_d;
      skid_dat_q  <= skid_dat_d;
      skid_sel_q  <= skid_sel_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = main_dat_q;
  assign out_sel   = main_sel_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_NWAY_PIPE_STATS_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  // Free-running wrap at 16 bits.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (drain) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= 16'h0000;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_count = beat_cnt_q;
`else
  assign beat_count = 16'h0000;
`endif

endmodule

// File: doc/mux_nway_pipe.md
Name: mux_nway_pipe

Overview:
- Parametrised N-channel, W-bit selector that generalises the team's 2:1 gate-level mux, where z = c ? b : a.
- Adds a valid/ready handshake, a registered output and a 2-entry skid buffer, so it can be inserted between pipeline stages without a combinational ready path.
- Flags out-of-range selects with a sticky error.
- With CHANNELS=2 and WIDTH=1 it is functionally the legacy 2:1 mux plus one cycle of latency.

Parameters:
WIDTH, 1, bit width of each data channel and of out_data
CHANNELS, 2, number of input channels (2..16)
SEL_W, 1, select width; must satisfy 2**SEL_W >= CHANNELS

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  CHANNELS*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH]
in_sel  input  SEL_W  channel select, sampled with in_data
in_valid  input  1  source has a beat
in_ready  output  1  block can accept a beat
out_data  output  WIDTH  selected channel data
out_sel  output  SEL_W  select value that produced out_data
out_valid  output  1  out_data/out_sel valid
out_ready  input  1  sink accepts a beat
sel_err  output  1  sticky: an accepted beat had in_sel >= CHANNELS
beat_count  output  16  accepted-output-beat counter (see Optional Feature)

Behaviour:
- Transfers:
  - Input transfer happens when in_valid && in_ready on a rising edge.
  - Output transfer happens when out_valid && out_ready on a rising edge.
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, out_data=0, out_sel=0, sel_err=0, beat_count=0.
  - Both buffer entries are empty.
  - The deassertion edge is used as-is; no internal synchroniser.
- Selection: value = in_data[in_sel*WIDTH +: WIDTH] when in_sel < CHANNELS, else all-zeros.
  - An out-of-range select on an accepted beat sets sel_err on the same edge.
  - The beat still passes through, carrying zero data and the raw select on out_sel.
- State machine, based on buffer occupancy:
  - EMPTY: out_valid=0, in_ready=1.
    - Accept → ONE; the main register loads.
  - ONE: out_valid=1, in_ready=1.
    - Accept with no drain → FULL; the new beat goes to the skid register.
    - Accept with drain → ONE; the main register reloads.
    - Drain only → EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - Drain → ONE; skid moves to main.
    - No accept is possible in FULL.
- in_ready is a registered signal: it equals (state != FULL) and never depends combinationally on out_ready.
- Latency: a beat accepted at edge n is visible on out_data with out_valid=1 after edge n, provided the buffer was EMPTY, or was ONE and drained at edge n.
- Ordering: strict FIFO; beats are never dropped or duplicated.
- Output hold: while out_valid && !out_ready, out_data and out_sel stay stable.
- in_sel/in_data are ignored when in_valid=0 or in_ready=0.
- sel_err is cleared only by reset.
- Reset mid-transfer: all buffered beats are discarded; no partial output.

Optional Feature:
- Macro: MUX_NWAY_PIPE_STATS_EN.
- Defined:
  - beat_count increments by 1 on every output transfer.
  - It wraps from 16'hFFFF to 16'h0000.
  - It is reset to 0 by rst_n.
- Not defined:
  - beat_count is tied to 16'h0000.
  - No counter flops are instantiated.
  - The port list is unchanged.

Test Plan:
- Legacy equivalence, CHANNELS=2, WIDTH=1, out_ready=1:
  - Sweep a,b,c over all 8 combinations, with in_data={b,a} and in_sel=c.
  - Each beat appears 1 cycle later with out_data = (c&b)|(a&~c).
  - sel_err stays 0.
- Backpressure, WIDTH=8, CHANNELS=4:
  - Send beats sel=0..3 back-to-back with data 8'h10,8'h21,8'h32,8'h43 on the selected channel.
  - Hold out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts; out_data holds 8'h10.
  - Release out_ready: outputs appear in order 10,21,32,43 with no loss.
- Out-of-range select, CHANNELS=3, SEL_W=2:
  - Accept one beat with in_sel=3.
  - out_data=0, out_sel=3, sel_err=1.
  - sel_err remains 1 after subsequent valid beats, until rst_n pulses low.
- Async reset mid-operation:
  - Buffer FULL; assert rst_n low between clock edges.
  - out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
  - After release, the first accepted beat is the first output.
- Stats, MUX_NWAY_PIPE_STATS_EN defined:
  - 70000 output transfers → beat_count = 70000 mod 65536 = 4464.
  - Same run with the macro undefined → beat_count = 0 throughout.
